// File: rtl/lcd_text_fetch.sv
// Character BRAM sequencer for the LCD path: streams NUM_CHARS bytes (two nibbles each) over
// valid/ready and interleaves single-character host writes between characters.
// Optional: define LCD_FETCH_BLANK_EN to present stored 8'h00 bytes as 8'h20 (space).
module lcd_text_fetch #(
  parameter logic [11:0] BASE_ADDR = 12'h000,
  parameter int          NUM_CHARS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        frame_done,
  output logic [7:0]  char_data,
  output logic [4:0]  char_pos,
  output logic        char_valid,
  input  logic        char_ready,
  input  logic        wr_req,
  input  logic [4:0]  wr_pos,
  input  logic [7:0]  wr_char,
  output logic        wr_ack,
  output logic [11:0] ram_addr,
  output logic        ram_en,
  output logic        ram_we,
  output logic [3:0]  ram_di,
  input  logic [3:0]  ram_do
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_LO, S_WR_HI, S_RD_LO, S_RD_HI, S_RD_CAP, S_PRESENT
  } state_t;

  localparam logic [6:0] NUM_C    = 7'(NUM_CHARS);
  localparam logic [5:0] LAST_IDX = 6'(NUM_CHARS - 1);

  state_t     state;
  logic [5:0] idx;
  logic [3:0] lo_q;
  logic [3:0] wr_hi_q;
  logic       wr_ok;

  // Nibble address of a character half; the 12-bit sum wraps mod 4096.
  function automatic logic [11:0] nib_addr(input logic [5:0] pos, input logic hi);
    return BASE_ADDR + {5'd0, pos, hi};
  endfunction

  function automatic logic [7:0] shown(input logic [7:0] b);
`ifdef LCD_FETCH_BLANK_EN
    return (b == 8'h00) ? 8'h20 : b;
`else
    return b;
`endif
  endfunction

  always_comb begin
    wr_ok = ({2'b00, wr_pos} < NUM_C);
  end

  // NOTE: every output is a register written with <= in this one block, so each output is
  // glitch-free and all reads within the block see the pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      idx        <= '0;
      lo_q       <= '0;
      wr_hi_q    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      char_data  <= '0;
      char_pos   <= '0;
      char_valid <= 1'b0;
      wr_ack     <= 1'b0;
      ram_addr   <= '0;
      ram_en     <= 1'b0;
      ram_we     <= 1'b0;
      ram_di     <= '0;
    end else begin
      frame_done <= 1'b0;
      wr_ack     <= 1'b0;
      unique case (state)
        S_IDLE: begin
          // wr_ack still high means the host has not yet dropped the request just served.
          if (wr_req && !wr_ack) begin
            if (wr_ok) begin
              state    <= S_WR_LO;
              ram_en   <= 1'b1;
              ram_we   <= 1'b1;
              ram_addr <= nib_addr({1'b0, wr_pos}, 1'b0);
              ram_di   <= wr_char[3:0];
              wr_hi_q  <= wr_char[7:4];
            end else begin
              wr_ack <= 1'b1;
            end
          end else if (start) begin
            busy     <= 1'b1;
            idx      <= '0;
            state    <= S_RD_LO;
            ram_en   <= 1'b1;
            ram_addr <= nib_addr(6'd0, 1'b0);
          end
        end
        S_WR_LO: begin
          state    <= S_WR_HI;
          ram_addr <= ram_addr + 12'd1;
          ram_di   <= wr_hi_q;
        end
        S_WR_HI: begin
          wr_ack <= 1'b1;
          ram_we <= 1'b0;
          ram_di <= '0;
          if (busy) begin
            state    <= S_RD_LO;
            ram_addr <= nib_addr(idx, 1'b0);
          end else begin
            state  <= S_IDLE;
            ram_en <= 1'b0;
          end
        end
        S_RD_LO: begin
          state    <= S_RD_HI;
          ram_addr <= nib_addr(idx, 1'b1);
        end
        S_RD_HI: begin
          state  <= S_RD_CAP;
          lo_q   <= ram_do;
          ram_en <= 1'b0;
        end
        S_RD_CAP: begin
          state      <= S_PRESENT;
          char_data  <= shown({ram_do, lo_q});
          char_pos   <= idx[4:0];
          char_valid <= 1'b1;
        end
        S_PRESENT: begin
          if (char_ready) begin
            char_valid <= 1'b0;
            if (idx == LAST_IDX) begin
              state      <= S_IDLE;
              busy       <= 1'b0;
              frame_done <= 1'b1;
            end else begin
              idx <= idx + 6'd1;
              if (wr_req && wr_ok) begin
                state    <= S_WR_LO;
                ram_en   <= 1'b1;
                ram_we   <= 1'b1;
                ram_addr <= nib_addr({1'b0, wr_pos}, 1'b0);
                ram_di   <= wr_char[3:0];
                wr_hi_q  <= wr_char[7:4];
              end else begin
                // An out-of-range write is acknowledged without touching the BRAM.
                wr_ack   <= wr_req;
                state    <= S_RD_LO;
                ram_en   <= 1'b1;
                ram_addr <= nib_addr(idx + 6'd1, 1'b0);
              end
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
